data_mem_responder: RTL and testbench

- Responder on the core's data-memory port. It services the single-cycle write-enable, address and write-data interface that the core's execute stage drives, and returns read data in the same cycle.
- Decodes each access into three regions:
  - a word-organised data RAM;
  - a small MMIO register file containing a free-running compare timer with interrupt;
  - everything else, which is unmapped and produces a sticky bus-error record.
- Sits between the core's data port and the top-level SoC wiring.

---
 rtl/data_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's single-cycle data port.
// Decodes each access to a word RAM, a small MMIO register file with a compare timer,
// or unmapped space. Unmapped space records a sticky bus error.
module data_mem_responder #(
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
  parameter int unsigned RAM_DEPTH = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wr_en_i,
  input  logic [31:0] mem_wd_addr_i,
  input  logic [31:0] mem_wr_data_i,
  output logic [31:0] mem_rd_data_o,
  output logic        timer_irq_o,
  output logic        bus_err_o
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  // 33-bit bounds so a region ending at the top of the address space cannot wrap
  localparam logic [32:0] RamLo  = {1'b0, RAM_BASE};
  localparam logic [32:0] RamHi  = {1'b0, RAM_BASE} + (33'(RAM_DEPTH) * 33'd4);
  localparam logic [32:0] MmioLo = {1'b0, MMIO_BASE};
  localparam logic [32:0] MmioHi = {1'b0, MMIO_BASE} + 33'd32;

  localparam logic [2:0] OffCtrl    = 3'd0;
  localparam logic [2:0] OffCount   = 3'd1;
  localparam logic [2:0] OffCmp     = 3'd2;
  localparam logic [2:0] OffStatus  = 3'd3;
  localparam logic [2:0] OffErrAddr = 3'd4;

  // Register state
  logic [31:0] r_ram [RAM_DEPTH];
  logic [2:0]  r_ctrl;      // {irq_en, auto_clr, en}
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_match;
  logic        r_err;
  logic [31:0] r_err_addr;

  // Decode
  logic [32:0]   w_addr_ext;
  logic          w_aligned;
  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [AW-1:0] w_ram_idx;
  logic [2:0]    w_mmio_off;
  logic          w_mmio_wr_ok;
  logic          w_wr_ram;
  logic          w_wr_mmio;
  logic          w_bad_wr;

  // Next-state
  logic [2:0]  w_ctrl_d;
  logic [31:0] w_count_d;
  logic [31:0] w_cmp_d;
  logic        w_match_d;
  logic        w_err_d;
  logic [31:0] w_err_addr_d;
  logic        w_new_match;
  logic [31:0] w_rd_data;

  assign w_addr_ext = {1'b0, mem_wd_addr_i};
  assign w_aligned  = (mem_wd_addr_i[1:0] == 2'b00);
  assign w_ram_hit  = (w_addr_ext >= RamLo) && (w_addr_ext < RamHi);
  assign w_mmio_hit = (w_addr_ext >= MmioLo) && (w_addr_ext < MmioHi);
  // Both regions are assumed naturally aligned to their size, so raw address bits index them
  assign w_ram_idx  = mem_wd_addr_i[AW+1:2];
  assign w_mmio_off = mem_wd_addr_i[4:2];

  // Only CTRL, COUNT, CMP and STATUS accept writes; ERR_ADDR and reserved slots are bad writes
  assign w_mmio_wr_ok = w_mmio_hit && w_aligned && !w_mmio_off[2];
  assign w_wr_ram     = mem_wr_en_i && w_ram_hit && w_aligned;
  assign w_wr_mmio    = mem_wr_en_i && w_mmio_wr_ok;
  assign w_bad_wr     = mem_wr_en_i && !(w_ram_hit && w_aligned) && !w_mmio_wr_ok;

  // RAM write port; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (w_wr_ram && rst_n) begin
      r_ram[w_ram_idx] <= mem_wr_data_i;
    end
  end

  // Timer advance, software writes and status set/clear
  always_comb begin
    w_ctrl_d     = r_ctrl;
    w_count_d    = r_count;
    w_cmp_d      = r_cmp;
    w_match_d    = r_match;
    w_err_d      = r_err;
    w_err_addr_d = r_err_addr;
    w_new_match  = 1'b0;

    if (r_ctrl[0]) begin
      w_new_match = (r_count == r_cmp);
      w_count_d   = (w_new_match && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
    end

    // Software writes override the timer's own COUNT update
    if (w_wr_mmio) begin
      unique case (w_mmio_off[1:0])
        OffCtrl[1:0]:  w_ctrl_d  = mem_wr_data_i[2:0];
        OffCount[1:0]: w_count_d = mem_wr_data_i;
        OffCmp[1:0]:   w_cmp_d   = mem_wr_data_i;
        OffStatus[1:0]: begin
          if (mem_wr_data_i[0]) w_match_d = 1'b0;
          if (mem_wr_data_i[1]) w_err_d   = 1'b0;
        end
      endcase
    end

    // Set beats clear when both happen on the same edge
    if (w_new_match) w_match_d = 1'b1;
    if (w_bad_wr) begin
      w_err_d = 1'b1;
      if (!r_err) w_err_addr_d = mem_wd_addr_i;
    end
  end

  // MMIO register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= 3'd0;
      r_count    <= 32'd0;
      r_cmp      <= 32'hFFFF_FFFF;
      r_match    <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= 32'd0;
    end else begin
      r_ctrl     <= w_ctrl_d;
      r_count    <= w_count_d;
      r_cmp      <= w_cmp_d;
      r_match    <= w_match_d;
      r_err      <= w_err_d;
      r_err_addr <= w_err_addr_d;
    end
  end

  // Zero-latency read mux; misaligned, unmapped and reserved reads return 0
  always_comb begin
    w_rd_data = 32'd0;
    if (w_aligned && w_ram_hit) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_aligned && w_mmio_hit) begin
      case (w_mmio_off)
        OffCtrl:    w_rd_data = {29'd0, r_ctrl};
        OffCount:   w_rd_data = r_count;
        OffCmp:     w_rd_data = r_cmp;
        OffStatus:  w_rd_data = {30'd0, r_err, r_match};
        OffErrAddr: w_rd_data = r_err_addr;
        default:    w_rd_data = 32'd0;
      endcase
    end
    mem_rd_data_o = rst_n ? w_rd_data : 32'd0;
  end

  assign timer_irq_o = r_match && r_ctrl[2];
  assign bus_err_o   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized traffic
// compared against a behavioural model of the memory map.
module tb_data_mem_responder;

  localparam logic [31:0] RamBase  = 32'h1000_0000;
  localparam logic [31:0] MmioBase = 32'h2000_0000;
  localparam int unsigned RamDepth = 4096;
  localparam logic [31:0] ACtrl    = 32'h2000_0000;
  localparam logic [31:0] ACount   = 32'h2000_0004;
  localparam logic [31:0] ACmp     = 32'h2000_0008;
  localparam logic [31:0] AStatus  = 32'h2000_000C;
  localparam logic [31:0] AErrAddr = 32'h2000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rd;
  logic        irq;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  data_mem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_wr_en_i   (wr_en),
    .mem_wd_addr_i (addr),
    .mem_wr_data_i (wdata),
    .mem_rd_data_o (rd),
    .timer_irq_o   (irq),
    .bus_err_o     (bus_err)
  );

  always #5 clk = ~clk;

  // Behavioural model of the memory map
  logic [31:0] m_ram [int unsigned];
  logic [2:0]  m_ctrl;
  logic [31:0] m_count, m_cmp, m_err_addr;
  logic        m_match, m_err;

  function automatic void m_reset();
    m_ctrl = 3'd0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
    m_match = 1'b0; m_err = 1'b0; m_err_addr = 32'd0;
    m_ram.delete();
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    int unsigned k;
    known = 1'b1;
    if (a[1:0] != 2'b00) return 32'd0;
    if (a >= RamBase && a < RamBase + 4 * RamDepth) begin
      k = (a - RamBase) / 4;
      if (m_ram.exists(k)) return m_ram[k];
      known = 1'b0;
      return 32'd0;
    end
    if (a >= MmioBase && a < MmioBase + 32) begin
      case ((a - MmioBase) / 4)
        0: return {29'd0, m_ctrl};
        1: return m_count;
        2: return m_cmp;
        3: return {30'd0, m_err, m_match};
        4: return m_err_addr;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic void m_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit ram_ok, mmio_ok, new_match, bad;
    int unsigned off;
    logic [31:0] cnt;
    ram_ok  = (a[1:0] == 2'b00) && a >= RamBase && a < RamBase + 4 * RamDepth;
    off     = (a - MmioBase) / 4;
    mmio_ok = (a[1:0] == 2'b00) && a >= MmioBase && a < MmioBase + 32 && off < 4;
    new_match = m_ctrl[0] && (m_count == m_cmp);
    cnt = m_count;
    if (m_ctrl[0]) cnt = (new_match && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    bad = we && !ram_ok && !mmio_ok;
    if (we && ram_ok) m_ram[(a - RamBase) / 4] = d;
    if (we && mmio_ok) begin
      if (off == 0) m_ctrl = d[2:0];
      if (off == 1) cnt = d;
      if (off == 2) m_cmp = d;
      if (off == 3) begin
        if (d[0]) m_match = 1'b0;
        if (d[1]) m_err = 1'b0;
      end
    end
    m_count = cnt;
    if (new_match) m_match = 1'b1;
    if (bad) begin
      if (!m_err) m_err_addr = a;
      m_err = 1'b1;
    end
  endfunction

  // Model tracks every active edge the DUT sees
  always @(posedge clk) if (rst_n) m_step(wr_en, addr, wdata);
  always @(negedge rst_n) m_reset();

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    wr_en = we; addr = a; wdata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_v [5];
    m_reset();
    rst_n = 1'b0;
    drive(1'b0, ACmp, 32'd0);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_rd: got %h exp 0", rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b exp 0", irq); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", bus_err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, MmioBase + 4 * i, 32'd0);
      checks++;
      if (rd !== exp_v[i]) begin
        failures++; $display("FAIL reset_reg%0d: got %h exp %h", i, rd, exp_v[i]);
      end
    end
  endtask

  task automatic test_ram();
    drive(1'b1, 32'h1000_0004, 32'hDEAD_BEEF); tick();
    drive(1'b1, 32'h1000_0008, 32'h1234_5678); tick();
    drive(1'b0, 32'h1000_0004, 32'd0);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rt4: got %h exp deadbeef", rd); end
    drive(1'b0, 32'h1000_0008, 32'd0);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL ram_rt8: got %h exp 12345678", rd); end
    // Same-cycle read sees the old word
    drive(1'b1, 32'h1000_0004, 32'h0BAD_F00D);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_old: got %h exp deadbeef", rd); end
    tick();
    drive(1'b0, 32'h1000_0004, 32'd0);
    checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL ram_new: got %h exp 0badf00d", rd); end
    drive(1'b1, 32'h1000_3FFC, 32'hA5A5_5A5A); tick();
    drive(1'b0, 32'h1000_3FFC, 32'd0);
    checks++; if (rd !== 32'hA5A5_5A5A) begin failures++; $display("FAIL ram_top: got %h exp a5a55a5a", rd); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL ram_noerr: got %b exp 0", bus_err); end
  endtask

  task automatic test_bad_writes();
    drive(1'b1, 32'h3000_0000, 32'h1111_1111); tick();
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL bad_err: got %b exp 1", bus_err); end
    drive(1'b0, AErrAddr, 32'd0);
    checks++; if (rd !== 32'h3000_0000) begin failures++; $display("FAIL bad_addr: got %h exp 30000000", rd); end
    drive(1'b1, 32'h1000_0002, 32'h2222_2222); tick();
    drive(1'b0, AErrAddr, 32'd0);
    checks++; if (rd !== 32'h3000_0000) begin failures++; $display("FAIL bad_sticky: got %h exp 30000000", rd); end
    drive(1'b1, AStatus, 32'h2); tick();
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL bad_clr: got %b exp 0", bus_err); end
    // ERR_ADDR is read-only: writing it is itself a bad write
    drive(1'b1, AErrAddr, 32'h5); tick();
    drive(1'b0, AErrAddr, 32'd0);
    checks++; if (rd !== 32'h2000_0010) begin failures++; $display("FAIL bad_ro: got %h exp 20000010", rd); end
    drive(1'b1, AStatus, 32'h2); tick();
    drive(1'b1, 32'h1000_4000, 32'h7); tick();
    drive(1'b0, AErrAddr, 32'd0);
    checks++; if (rd !== 32'h1000_4000) begin failures++; $display("FAIL bad_ramend: got %h exp 10004000", rd); end
    drive(1'b0, 32'h1000_4000, 32'd0);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL unmapped_rd: got %h exp 0", rd); end
    drive(1'b1, AStatus, 32'h2); tick();
  endtask

  task automatic test_timer_match();
    logic [31:0] seq [7];
    logic exp_irq;
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
    drive(1'b1, ACmp, 32'd5); tick();
    drive(1'b1, ACount, 32'd0); tick();
    drive(1'b1, ACtrl, 32'h7); tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, ACount, 32'd0);
      exp_irq = (i == 6);
      checks++;
      if (rd !== seq[i]) begin failures++; $display("FAIL tmr_count%0d: got %h exp %h", i, rd, seq[i]); end
      checks++;
      if (irq !== exp_irq) begin failures++; $display("FAIL tmr_irq%0d: got %b exp %b", i, irq, exp_irq); end
      tick();
    end
    drive(1'b1, AStatus, 32'h1); tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tmr_w1c: got %b exp 0", irq); end
  endtask

  task automatic test_set_clear();
    bit found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, ACount, 32'd0);
      checks++;
      if (rd !== m_count) begin failures++; $display("FAIL sc_count: got %h exp %h", rd, m_count); end
      if (m_count == 32'd5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL sc_reach: got timeout exp count 5"); end
    drive(1'b1, AStatus, 32'h1); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL sc_irq: got %b exp 1", irq); end
    drive(1'b0, AStatus, 32'd0);
    checks++; if (rd[0] !== 1'b1) begin failures++; $display("FAIL sc_match: got %b exp 1", rd[0]); end
    drive(1'b1, ACtrl, 32'h0); tick();
    drive(1'b1, AStatus, 32'h3); tick();
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4];
    logic [31:0] exp_st;
    seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
    drive(1'b1, ACount, 32'hFFFF_FFFE); tick();
    drive(1'b1, ACmp, 32'd0); tick();
    drive(1'b1, ACtrl, 32'h1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ACount, 32'd0);
      checks++;
      if (rd !== seq[i]) begin failures++; $display("FAIL wrap_count%0d: got %h exp %h", i, rd, seq[i]); end
      drive(1'b0, AStatus, 32'd0);
      exp_st = (i == 3) ? 32'd1 : 32'd0;
      checks++;
      if (rd !== exp_st) begin failures++; $display("FAIL wrap_status%0d: got %h exp %h", i, rd, exp_st); end
      tick();
    end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL wrap_noirq: got %b exp 0", irq); end
    drive(1'b1, ACount, 32'h10); tick();
    drive(1'b0, ACount, 32'd0);
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL wrap_wprio: got %h exp 10", rd); end
    drive(1'b1, ACtrl, 32'h0); tick();
    drive(1'b1, AStatus, 32'h3); tick();
  endtask

  task automatic test_random();
    logic [31:0] bounds [6];
    logic [31:0] a, d, exp_rd;
    logic we;
    bit known;
    int unsigned sel;
    bounds = '{32'h1000_3FFC, 32'h1000_4000, 32'h0FFF_FFFC,
               32'h2000_001C, 32'h2000_0020, 32'h1FFF_FFFC};
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = RamBase + 4 * $urandom_range(0, 15);
        4, 5, 6:    a = MmioBase + 4 * $urandom_range(0, 7);
        7:          a = $urandom;
        8:          a = ($urandom_range(0, 1) ? RamBase : MmioBase) + $urandom_range(1, 3);
        default:    a = bounds[$urandom_range(0, 5)];
      endcase
      we = ($urandom_range(0, 2) == 0);
      d  = (a >= MmioBase && a < MmioBase + 32) ? 32'($urandom_range(0, 15)) : $urandom;
      drive(we, a, d);
      exp_rd = m_read(a, known);
      if (known) begin
        checks++;
        if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rd@%h: got %h exp %h", a, rd, exp_rd); end
      end
      tick();
      checks++;
      if (irq !== (m_match & m_ctrl[2])) begin
        failures++; $display("FAIL rnd_irq: got %b exp %b", irq, m_match & m_ctrl[2]);
      end
      checks++;
      if (bus_err !== m_err) begin failures++; $display("FAIL rnd_err: got %b exp %b", bus_err, m_err); end
    end
    drive(1'b1, ACtrl, 32'h0); tick();
    drive(1'b1, AStatus, 32'h3); tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_v [5];
    drive(1'b1, ACmp, 32'd1); tick();
    drive(1'b1, ACount, 32'd0); tick();
    drive(1'b1, 32'h4000_0000, 32'd9); tick();
    drive(1'b1, ACtrl, 32'h5); tick();
    drive(1'b0, ACount, 32'd0);
    repeat (3) tick();
    checks++; if (rd !== 32'd3) begin failures++; $display("FAIL mid_pre_count: got %h exp 3", rd); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mid_pre_irq: got %b exp 1", irq); end
    rst_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq: got %b exp 0", irq); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL mid_err: got %b exp 0", bus_err); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mid_rd: got %h exp 0", rd); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, MmioBase + 4 * i, 32'd0);
      checks++;
      if (rd !== exp_v[i]) begin
        failures++; $display("FAIL mid_reg%0d: got %h exp %h", i, rd, exp_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_bad_writes();
    test_timer_match();
    test_set_clear();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
